// File: rtl/seq_divider_if.sv
// Start/done handshake bundle for seq_divider: operands in, quotient/remainder/status out.
interface seq_divider_if #(
  parameter int W = 1024
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div0;

  modport master (output start, a, b, input busy, done, q, r, div0);
  modport slave  (input start, a, b, output busy, done, q, r, div0);
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, BPC quotient bits per clock, start/done handshake.
// Divide-by-zero completes in one edge with q = all ones, r = a, div0 = 1.
module seq_divider #(
  parameter int W   = 1024,
  parameter int BPC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int          N     = W / BPC;
  localparam int          CW    = $clog2(N + 1);
  localparam int unsigned STEPS = BPC;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  qsh;
  logic [W-1:0]  dvs;
  logic [W:0]    rem;
  logic [W-1:0]  q_reg;
  logic [W-1:0]  r_reg;
  logic          div0_reg;

  logic [W-1:0]  qsh_n;
  logic [W:0]    rem_n;
  logic [W+1:0]  diff;

  // Borrow is taken from a W+2-bit difference so divisors with the MSB set stay exact.
  always_comb begin
    qsh_n = qsh;
    rem_n = rem;
    diff  = '0;
    for (int unsigned i = 0; i < STEPS; i++) begin
      rem_n = {rem_n[W-1:0], qsh_n[W-1]};
      qsh_n = {qsh_n[W-2:0], 1'b0};
      diff  = {1'b0, rem_n} - {2'b00, dvs};
      if (!diff[W+1]) begin
        rem_n    = diff[W:0];
        qsh_n[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      qsh      <= '0;
      dvs      <= '0;
      rem      <= '0;
      q_reg    <= '0;
      r_reg    <= '0;
      div0_reg <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            qsh <= bus.a;
            dvs <= bus.b;
            rem <= '0;
            cnt <= '0;
            if (bus.b == '0) begin
              q_reg    <= '1;
              r_reg    <= bus.a;
              div0_reg <= 1'b1;
              state    <= DONE;
            end else begin
              div0_reg <= 1'b0;
              state    <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          qsh <= qsh_n;
          rem <= rem_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            q_reg <= qsh_n;
            r_reg <= rem_n[W-1:0];
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.q    = q_reg;
  assign bus.r    = r_reg;
  assign bus.div0 = div0_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed 8-bit cases (BPC 1 and 2) and random 1024-bit divides
// (BPC 1, 2, 4) checked against plain / and % arithmetic.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // 8-bit instances: index 0 -> BPC=1, index 1 -> BPC=2
  logic       ss[2];
  logic [7:0] sa[2], sb[2], sq[2], sr[2];
  logic       sbusy[2], sdone[2], sd0[2];

  for (genvar gs = 0; gs < 2; gs++) begin : gsm
    seq_divider_if #(.W(8)) bus ();
    seq_divider #(.W(8), .BPC(gs + 1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    assign bus.start = ss[gs];
    assign bus.a     = sa[gs];
    assign bus.b     = sb[gs];
    assign sq[gs]    = bus.q;
    assign sr[gs]    = bus.r;
    assign sbusy[gs] = bus.busy;
    assign sdone[gs] = bus.done;
    assign sd0[gs]   = bus.div0;
  end

  // 1024-bit instances: index g -> BPC = 1<<g
  logic          ws[3];
  logic [1023:0] wa[3], wb[3], wq[3], wr[3];
  logic          wbusy[3], wdone[3], wd0[3];

  for (genvar g = 0; g < 3; g++) begin : gw
    seq_divider_if #(.W(1024)) bus ();
    seq_divider #(.W(1024), .BPC(1 << g)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    assign bus.start = ws[g];
    assign bus.a     = wa[g];
    assign bus.b     = wb[g];
    assign wq[g]     = bus.q;
    assign wr[g]     = bus.r;
    assign wbusy[g]  = bus.busy;
    assign wdone[g]  = bus.done;
    assign wd0[g]    = bus.div0;
  end

  // Latency counts the accepting edge as edge 1.
  task automatic run8(input int s, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] q, output logic [7:0] r, output logic d0,
                      output int lat);
    @(negedge clk);
    sa[s] = a; sb[s] = b; ss[s] = 1'b1;
    @(posedge clk);
    #1 ss[s] = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!sdone[s] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    q = sq[s]; r = sr[s]; d0 = sd0[s];
  endtask

  task automatic run1k(input int g, input logic [1023:0] a, input logic [1023:0] b,
                       output logic [1023:0] q, output logic [1023:0] r, output logic d0,
                       output int lat);
    @(negedge clk);
    wa[g] = a; wb[g] = b; ws[g] = 1'b1;
    @(posedge clk);
    #1 ws[g] = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!wdone[g] && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    q = wq[g]; r = wr[g]; d0 = wd0[g];
  endtask

  function automatic logic [1023:0] rnd1k();
    logic [1023:0] v;
    for (int k = 0; k < 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic test_reset();
    logic [8:0] flags;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin ss[i] = 1'b0; sa[i] = '0; sb[i] = '0; end
    for (int i = 0; i < 3; i++) begin ws[i] = 1'b0; wa[i] = '0; wb[i] = '0; end
    #1 rst_n = 1'b0;
    #2;
    flags = {sbusy[0], sdone[0], sd0[0], sbusy[1], sdone[1], wbusy[0], wdone[0], wd0[2], wbusy[2]};
    total++;
    if (flags !== 9'b0) $display("FAIL reset_flags got=%b exp=%b", flags, 9'b0);
    else passed++;
    total++;
    if ({sq[0], sr[0], sq[1], sr[1]} !== 32'h0)
      $display("FAIL reset_qr8 got=%h exp=0", {sq[0], sr[0], sq[1], sr[1]});
    else passed++;
    total++;
    if ((wq[1] | wr[1]) !== '0) $display("FAIL reset_qr1k got=%h exp=0", wq[1][63:0] | wr[1][63:0]);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check8(input string name, input logic [7:0] q, input logic [7:0] r,
                        input logic d0, input int lat, input logic [7:0] eq,
                        input logic [7:0] er, input logic ed, input int elat);
    total++;
    if (q !== eq) $display("FAIL %s_q got=%0d exp=%0d", name, q, eq); else passed++;
    total++;
    if (r !== er) $display("FAIL %s_r got=%0d exp=%0d", name, r, er); else passed++;
    total++;
    if (d0 !== ed) $display("FAIL %s_div0 got=%0b exp=%0b", name, d0, ed); else passed++;
    total++;
    if (lat != elat) $display("FAIL %s_latency got=%0d exp=%0d", name, lat, elat); else passed++;
  endtask

  task automatic test_basic();
    logic [7:0] q, r; logic d0; int lat;
    run8(0, 8'd100, 8'd7, q, r, d0, lat);
    check8("basic_100_7", q, r, d0, lat, 8'd14, 8'd2, 1'b0, 9);
  endtask

  task automatic test_edges();
    logic [7:0] q, r; logic d0; int lat;
    run8(0, 8'd255, 8'd200, q, r, d0, lat);
    check8("msb_255_200", q, r, d0, lat, 8'd1, 8'd55, 1'b0, 9);
    run8(0, 8'd5, 8'd9, q, r, d0, lat);
    check8("small_5_9", q, r, d0, lat, 8'd0, 8'd5, 1'b0, 9);
    run8(0, 8'd0, 8'd3, q, r, d0, lat);
    check8("zero_0_3", q, r, d0, lat, 8'd0, 8'd0, 1'b0, 9);
    run8(0, 8'd173, 8'd173, q, r, d0, lat);
    check8("equal_173", q, r, d0, lat, 8'd1, 8'd0, 1'b0, 9);
  endtask

  task automatic test_div0();
    logic [7:0] q, r; logic d0; int lat;
    run8(0, 8'd37, 8'd0, q, r, d0, lat);
    check8("div0_37_0", q, r, d0, lat, 8'hFF, 8'd37, 1'b1, 1);
    run8(0, 8'd9, 8'd3, q, r, d0, lat);
    check8("after_div0_9_3", q, r, d0, lat, 8'd3, 8'd0, 1'b0, 9);
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    sa[1] = 8'd200; sb[1] = 8'd13; ss[1] = 1'b1;
    @(posedge clk);
    #1 ss[1] = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!sdone[1] && lat < 64) begin
      if (lat == 2) begin
        total++;
        if (sbusy[1] !== 1'b1) $display("FAIL midrun_busy got=%0b exp=1", sbusy[1]); else passed++;
        ss[1] = 1'b1; sa[1] = 8'd1; sb[1] = 8'd1;
      end else begin
        ss[1] = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    ss[1] = 1'b0;
    check8("bpc2_200_13", sq[1], sr[1], sd0[1], lat, 8'd15, 8'd5, 1'b0, 5);
    // start held in the DONE cycle is accepted on that edge
    sa[1] = 8'd77; sb[1] = 8'd6; ss[1] = 1'b1;
    @(posedge clk);
    #1 ss[1] = 1'b0;
    lat = 1;
    @(negedge clk);
    total++;
    if (sbusy[1] !== 1'b1) $display("FAIL b2b_busy got=%0b exp=1", sbusy[1]); else passed++;
    total++;
    if (sq[1] !== 8'd15) $display("FAIL midrun_q_held got=%0d exp=15", sq[1]); else passed++;
    while (!sdone[1] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check8("b2b_77_6", sq[1], sr[1], sd0[1], lat, 8'd12, 8'd5, 1'b0, 5);
  endtask

  task automatic test_reset_midrun();
    logic [7:0] q, r; logic d0; int lat;
    int seen_done;
    @(negedge clk);
    sa[0] = 8'd100; sb[0] = 8'd7; ss[0] = 1'b1;
    @(posedge clk);
    #1 ss[0] = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (sbusy[0] !== 1'b1) $display("FAIL prereset_busy got=%0b exp=1", sbusy[0]); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({sbusy[0], sdone[0], sq[0], sr[0]} !== 18'h0)
      $display("FAIL async_reset got=%h exp=0", {sbusy[0], sdone[0], sq[0], sr[0]});
    else passed++;
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (sdone[0]) seen_done++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (sdone[0]) seen_done++;
    end
    total++;
    if (seen_done != 0) $display("FAIL aborted_done got=%0d exp=0", seen_done); else passed++;
    run8(0, 8'd200, 8'd9, q, r, d0, lat);
    check8("post_reset_200_9", q, r, d0, lat, 8'd22, 8'd2, 1'b0, 9);
  endtask

  task automatic test_random_wide(input int g, input int n);
    logic [1023:0] a, b, q, r, eq, er;
    logic d0, ed;
    int lat, elat;
    for (int i = 0; i < n; i++) begin
      case (i % 5)
        0: begin a = rnd1k(); b = rnd1k(); end
        1: begin a = rnd1k(); b = rnd1k(); b[1023] = 1'b1; end
        2: begin b = rnd1k(); b[1023] = 1'b1; a = rnd1k() >> $urandom_range(1, 600); end
        3: begin a = rnd1k(); b = rnd1k() >> $urandom_range(0, 1000); end
        default: begin b = rnd1k() >> $urandom_range(0, 1000); a = b; end
      endcase
      if (i == n - 1) b = '0;
      if (b == '0) begin
        eq = '1; er = a; ed = 1'b1; elat = 1;
      end else begin
        eq = a / b; er = a % b; ed = 1'b0; elat = 1024 / (1 << g) + 1;
      end
      run1k(g, a, b, q, r, d0, lat);
      total++;
      if (q !== eq) $display("FAIL wide%0d_q[%0d] got=%h exp=%h", g, i, q[63:0], eq[63:0]); else passed++;
      total++;
      if (r !== er) $display("FAIL wide%0d_r[%0d] got=%h exp=%h", g, i, r[63:0], er[63:0]); else passed++;
      total++;
      if (d0 !== ed) $display("FAIL wide%0d_div0[%0d] got=%0b exp=%0b", g, i, d0, ed); else passed++;
      total++;
      if (lat != elat) $display("FAIL wide%0d_latency[%0d] got=%0d exp=%0d", g, i, lat, elat); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div0();
    test_back_to_back();
    test_reset_midrun();
    test_random_wide(0, 20);
    test_random_wide(1, 40);
    test_random_wide(2, 80);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
